// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg: phase and instruction-class codes shared by the sequencer and its bench
package phase_sequencer_pkg;
  localparam int WAIT_MAX = 15;
  localparam int WAIT_W = 4;
  typedef enum logic [2:0] {
    PH_FETCH = 3'd0,
    PH_DECODE = 3'd1,
    PH_EXEC = 3'd2,
    PH_MEM = 3'd3,
    PH_WB = 3'd4,
    PH_HALT = 3'd5,
    PH_FAULT = 3'd6
  } phase_t;
  typedef enum logic [2:0] {
    CL_ALU = 3'd0,
    CL_ALUI = 3'd1,
    CL_LOAD = 3'd2,
    CL_STORE = 3'd3,
    CL_JUMP = 3'd4,
    CL_HLT = 3'd7
  } class_t;
endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control-side bundle between unit_control, memories and the sequencer
interface phase_sequencer_if #(parameter int CNT_W = 32);
  logic [2:0] instr_type;
  logic im_ready, dm_ready, w_pc_req, w_dm_req, w_rb_req;
  logic [2:0] w_rf_req;
  logic w_ir, w_pc, w_dm, w_rb;
  logic [2:0] w_rf;
  logic im_req, dm_req, instr_done, halted, fault;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;
  modport master (
    output instr_type, im_ready, dm_ready, w_pc_req, w_dm_req, w_rb_req, w_rf_req,
    input w_ir, w_pc, w_dm, w_rb, w_rf, im_req, dm_req, state, instr_done, halted, fault, retired
  );
  modport slave (
    input instr_type, im_ready, dm_ready, w_pc_req, w_dm_req, w_rb_req, w_rf_req,
    output w_ir, w_pc, w_dm, w_rb, w_rf, im_req, dm_req, state, instr_done, halted, fault, retired
  );
endinterface

// File: rtl/phase_sequencer_wait_timer.sv
// seq_wait_timer: counts consecutive not-ready cycles; expired flags the last tolerated one
module seq_wait_timer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = phase_sequencer_pkg::WAIT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [WAIT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign expired = en && cnt == WAIT_W'(WAIT_MAX - 1);
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: steps each instruction through fetch/decode/exec/mem/wb and gates architectural writes
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = phase_sequencer_pkg::WAIT_MAX,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  phase_sequencer_if.slave bus
);
  phase_t state, nxt;
  logic [CNT_W-1:0] retired;
  logic waiting, ready, expired, is_store, is_mem;
  assign waiting = state == PH_FETCH || state == PH_MEM;
  assign ready = state == PH_FETCH ? bus.im_ready : bus.dm_ready;
  assign is_store = bus.instr_type == CL_STORE;
  assign is_mem = is_store || bus.instr_type == CL_LOAD;
  seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(!waiting || ready),
    .en(waiting && !ready),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= PH_FETCH;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) retired <= '0;
    else if (bus.instr_done) retired <= retired + 1'b1;
  end
  always_comb begin
    nxt = state;
    bus.w_ir = 1'b0;
    bus.w_pc = 1'b0;
    bus.w_dm = 1'b0;
    bus.w_rb = 1'b0;
    bus.w_rf = 3'b000;
    bus.im_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.instr_done = 1'b0;
    case (state)
      PH_FETCH: begin
        bus.im_req = 1'b1;
        bus.w_ir = bus.im_ready;
        nxt = bus.im_ready ? PH_DECODE : expired ? PH_FAULT : PH_FETCH;
      end
      PH_DECODE: nxt = bus.instr_type == CL_HLT ? PH_HALT : PH_EXEC;
      PH_EXEC: begin
        bus.w_rf = bus.w_rf_req;
        if (is_mem) nxt = PH_MEM;
        else if (bus.w_rb_req) nxt = PH_WB;
        else begin
          // non-jumps always advance the PC; jumps follow unit_control
          bus.w_pc = bus.w_pc_req || bus.instr_type != CL_JUMP;
          bus.instr_done = 1'b1;
          nxt = PH_FETCH;
        end
      end
      PH_MEM: begin
        bus.dm_req = 1'b1;
        bus.w_dm = bus.w_dm_req && is_store;
        if (bus.dm_ready) begin
          bus.w_pc = is_store;
          bus.instr_done = is_store;
          nxt = is_store ? PH_FETCH : PH_WB;
        end else if (expired) nxt = PH_FAULT;
      end
      PH_WB: begin
        bus.w_rb = 1'b1;
        bus.w_pc = 1'b1;
        bus.instr_done = 1'b1;
        nxt = PH_FETCH;
      end
      PH_HALT: nxt = PH_HALT;
      default: nxt = PH_FAULT;
    endcase
  end
  assign bus.state = state;
  assign bus.halted = state == PH_HALT;
  assign bus.fault = state == PH_FAULT;
  assign bus.retired = retired;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed per-cycle vectors queued as expectations, checked by a separate monitor
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;
  typedef struct packed {
    logic [2:0] st;
    logic ir, pc, dm, rb;
    logic [2:0] rf;
    logic imr, dmr, dn, h, f;
    logic [3:0] ret;
  } obs_t;
  typedef struct packed {
    logic [63:0] tag;
    obs_t o;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  item_t q[$];
  item_t it;
  obs_t act;
  phase_sequencer_if #(.CNT_W(4)) bus ();
  phase_sequencer #(.WAIT_MAX(15), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t o(input logic [2:0] st, input logic ir, pc, dm, rb, input logic [2:0] rf,
                             input logic imr, dmr, dn, input logic [3:0] ret);
    return '{st, ir, pc, dm, rb, rf, imr, dmr, dn, st == PH_HALT, st == PH_FAULT, ret};
  endfunction
  task automatic setin(input logic [2:0] ty, input logic im, dm, pcr, dmr, rbr, input logic [2:0] rfr);
    bus.instr_type = ty;
    bus.im_ready = im;
    bus.dm_ready = dm;
    bus.w_pc_req = pcr;
    bus.w_dm_req = dmr;
    bus.w_rb_req = rbr;
    bus.w_rf_req = rfr;
  endtask
  task automatic chk(input logic [63:0] tag, input obs_t e);
    q.push_back('{tag, e});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      it = q.pop_front();
      act = {bus.state, bus.w_ir, bus.w_pc, bus.w_dm, bus.w_rb, bus.w_rf, bus.im_req, bus.dm_req,
             bus.instr_done, bus.halted, bus.fault, bus.retired};
      checks++;
      if (act !== it.o) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", it.tag, act, it.o);
      end
    end
  end
  initial begin
    setin(CL_ALU, 0, 0, 0, 0, 0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset", o(PH_FETCH, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    setin(CL_ALU, 1, 0, 0, 0, 1, 3'b111);
    chk("alu_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    chk("alu_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    chk("alu_e", o(PH_EXEC, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0));
    chk("alu_wb", o(PH_WB, 0, 1, 0, 1, 3'b000, 0, 0, 1, 0));
    setin(CL_STORE, 1, 0, 0, 1, 1, 3'b010);
    chk("st_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 1));
    chk("st_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));
    chk("st_e", o(PH_EXEC, 0, 0, 0, 0, 3'b010, 0, 0, 0, 1));
    repeat (3) chk("st_mwait", o(PH_MEM, 0, 0, 1, 0, 3'b000, 0, 1, 0, 1));
    setin(CL_STORE, 1, 1, 0, 1, 1, 3'b010);
    chk("st_mrdy", o(PH_MEM, 0, 1, 1, 0, 3'b000, 0, 1, 1, 1));
    setin(CL_JUMP, 1, 0, 0, 0, 0, 3'b000);
    chk("jn_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 2));
    chk("jn_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 2));
    chk("jn_e", o(PH_EXEC, 0, 0, 0, 0, 3'b000, 0, 0, 1, 2));
    setin(CL_ALU, 1, 0, 0, 0, 0, 3'b000);
    chk("alu2_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 3));
    chk("alu2_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3));
    chk("alu2_e", o(PH_EXEC, 0, 1, 0, 0, 3'b000, 0, 0, 1, 3));
    setin(CL_JUMP, 1, 0, 1, 0, 0, 3'b000);
    chk("jt_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 4));
    chk("jt_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4));
    chk("jt_e", o(PH_EXEC, 0, 1, 0, 0, 3'b000, 0, 0, 1, 4));
    setin(CL_LOAD, 1, 0, 0, 1, 1, 3'b000);
    chk("ldr_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 5));
    chk("ldr_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 5));
    chk("ldr_e", o(PH_EXEC, 0, 0, 0, 0, 3'b000, 0, 0, 0, 5));
    rst_n = 1'b0;
    chk("ldr_m", o(PH_MEM, 0, 0, 0, 0, 3'b000, 0, 1, 0, 5));
    rst_n = 1'b1;
    setin(CL_LOAD, 0, 0, 0, 1, 1, 3'b000);
    chk("ldr_rst", o(PH_FETCH, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    setin(CL_LOAD, 1, 0, 0, 1, 0, 3'b000);
    chk("ld_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    chk("ld_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    chk("ld_e", o(PH_EXEC, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    setin(CL_LOAD, 1, 1, 0, 1, 0, 3'b000);
    chk("ld_m", o(PH_MEM, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0));
    chk("ld_wb", o(PH_WB, 0, 1, 0, 1, 3'b000, 0, 0, 1, 0));
    setin(CL_ALU, 1, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 15; i++) begin
      chk("wrap_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 4'(i + 1)));
      chk("wrap_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 4'(i + 1)));
      chk("wrap_e", o(PH_EXEC, 0, 1, 0, 0, 3'b000, 0, 0, 1, 4'(i + 1)));
    end
    setin(CL_ALU, 0, 0, 0, 0, 0, 3'b000);
    chk("wrapped", o(PH_FETCH, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    repeat (14) chk("im_wait", o(PH_FETCH, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    setin(CL_ALU, 1, 1, 1, 1, 1, 3'b111);
    chk("fault", o(PH_FAULT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    repeat (3) chk("f_sticky", o(PH_FAULT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    rst_n = 1'b0;
    chk("f_rst", o(PH_FAULT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    rst_n = 1'b1;
    setin(CL_HLT, 1, 0, 0, 0, 0, 3'b000);
    chk("hlt_f", o(PH_FETCH, 1, 0, 0, 0, 3'b000, 1, 0, 0, 0));
    chk("hlt_d", o(PH_DECODE, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    setin(CL_HLT, 1, 1, 1, 1, 1, 3'b111);
    repeat (20) chk("halted", o(PH_HALT, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
